difftest_step_scheduler: RTL and testbench
==========================================

Name: difftest_step_scheduler

Overview:
- Sequences difftest checking between the DUT commit stream and the software checker bridge.
- Accumulates per-cycle commit step counts into batches and issues one batched step request at a time over a valid/ready handshake.
- Waits for the checker's result code, then decodes it into perf-control pulses and a terminal halt.
- Sits between the DUT difftest_step output and the simulation endpoint. It also provides DUT stall back-pressure and stuck detection.

Parameters:
- STEP_W, 8, width of the per-cycle commit step input.
- CNT_W, 16, width of the accumulator and of req_nstep.
- BATCH, 64, accumulated step count that triggers a request.
- FLUSH_CYCLES, 32, cycles in ACCUM with a nonzero accumulator before a partial batch is forced out.
- STALL_THRESH, 1024, accumulator level at or above which dut_stall is asserted.
- STUCK_LIMIT, 5000, consecutive zero-step cycles before stuck is raised; 0 disables the check.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_step  in  STEP_W  steps committed by the DUT this cycle
- req_valid  out  1  batched step request valid
- req_ready  in  1  checker accepts the request
- req_nstep  out  CNT_W  step count carried by the request
- resp_valid  in  1  checker result valid, single-cycle
- resp_code  in  8  checker result: 0 OK, 1 DONE, 2 FAIL, 3 WARMUP, others reserved
- dut_stall  out  1  DUT must hold commits
- perf_clean  out  1  one-cycle pulse on a WARMUP result
- perf_dump  out  1  one-cycle pulse on entering HALT
- halted  out  1  sticky, scheduler stopped
- result  out  8  last terminal code (DONE or FAIL)
- stuck  out  1  sticky stuck indication
- overflow  out  1  sticky accumulator overflow indication

Behaviour:
- Reset is asynchronous and active-high; clock is clock.
- Reset values: all outputs 0; state=ACCUM; acc=0; flush_timer=0; stuck_timer=0.
- acc_next = acc + in_step, zero-extended and computed at CNT_W+1 bits.
  - If the carry bit is set: overflow<=1 and acc saturates to all-ones.
  - in_step is ignored while halted.
- States:
  - ACCUM: if acc_next>=BATCH, or acc_next>0 and flush_timer==FLUSH_CYCLES-1, then on that edge req_nstep<=acc_next (saturated), acc<=0, flush_timer<=0, state<=ISSUE. Otherwise acc<=acc_next. flush_timer increments while acc_next>0 and clears when acc_next==0.
  - ISSUE: req_valid=1 and req_nstep is held stable until req_valid&&req_ready, then go to WAIT. acc<=acc_next continues (no reset of in-flight steps).
  - WAIT: acc<=acc_next continues. On resp_valid:
    - code 0: go to ACCUM.
    - code 3: perf_clean pulses on the next cycle; go to ACCUM.
    - code 1 or 2: result<=code, halted<=1, perf_dump pulses on the next cycle; go to HALT.
    - Reserved codes are treated as FAIL (result<=2).
  - HALT: terminal; exits only via reset. req_valid=0.
- Latency: in_step that makes acc_next>=BATCH, sampled at edge t, gives req_valid high after edge t. Only one request is outstanding at a time. resp_valid outside WAIT is ignored.
- A request is not issued if acc==0; no zero-length requests.
- dut_stall = halted || acc>=STALL_THRESH. It is a registered-state decode with no combinational path from in_step.
- Stuck detection:
  - stuck_timer increments on cycles with in_step==0 and !halted, and clears on in_step!=0.
  - When STUCK_LIMIT>0 and stuck_timer reaches STUCK_LIMIT, stuck<=1 (sticky).
  - stuck_timer keeps counting while dut_stall is asserted.
- Simultaneous events:
  - resp_valid with a DONE code in the same cycle as an ACCUM batch condition: HALT wins, the batch is discarded and acc is frozen.
  - A batch condition while in ISSUE or WAIT only accumulates; the next request is evaluated after returning to ACCUM.
- Reset asserted mid-ISSUE or mid-WAIT: req_valid drops immediately (asynchronous) and all pending counts are lost.

Test Plan:
- in_step=8 for 8 cycles, req_ready=1 -> req_valid rises after edge 8 with req_nstep=64; acc=0; one-cycle handshake; state WAIT.
- in_step=5 once, then 0 -> after 32 cycles req_valid with req_nstep=5 (flush path).
- req_ready=0 for 10 cycles during ISSUE while in_step=10 -> req_nstep stays 64, acc reaches 100, no second request; accept, resp code 0 -> next request req_nstep=100.
- Hold req_ready=0, in_step=200 -> dut_stall=1 once acc>=1024; overflow stays 0.
- Response code 3 -> perf_clean single pulse; then code 1 -> result=1, halted=1, perf_dump single pulse; later in_step is ignored and req_valid stays 0.
- in_step=0 for 5000 cycles -> stuck=1; assert reset mid-WAIT -> all outputs 0 asynchronously, stuck cleared.

Source files
------------

// File: rtl/difftest_step_scheduler.sv
// Batches DUT commit steps into one-at-a-time checker requests and
// decodes checker results into perf pulses and a terminal halt.
module difftest_step_scheduler #(
    parameter int STEP_W       = 8,
    parameter int CNT_W        = 16,
    parameter int BATCH        = 64,
    parameter int FLUSH_CYCLES = 32,
    parameter int STALL_THRESH = 1024,
    parameter int STUCK_LIMIT  = 5000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [STEP_W-1:0] in_step,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [CNT_W-1:0]  req_nstep,
    input  logic              resp_valid,
    input  logic [7:0]        resp_code,
    output logic              dut_stall,
    output logic              perf_clean,
    output logic              perf_dump,
    output logic              halted,
    output logic [7:0]        result,
    output logic              stuck,
    output logic              overflow
);

    typedef enum logic [1:0] {ACCUM, ISSUE, WAIT, HALT} state_t;

    localparam int FT_W = $clog2(FLUSH_CYCLES + 1);
    localparam int ST_W = (STUCK_LIMIT > 0) ? $clog2(STUCK_LIMIT + 1) : 1;

    localparam logic [CNT_W-1:0] BATCH_C = CNT_W'(BATCH);
    localparam logic [CNT_W-1:0] STALL_C = CNT_W'(STALL_THRESH);
    localparam logic [FT_W-1:0]  FT_LAST = FT_W'(FLUSH_CYCLES - 1);
    localparam logic [ST_W-1:0]  ST_MAX  = ST_W'(STUCK_LIMIT);
    localparam logic [ST_W-1:0]  ST_PRE  =
        ST_W'((STUCK_LIMIT > 0) ? STUCK_LIMIT - 1 : 0);

    state_t            state;
    logic [CNT_W-1:0]  acc;
    logic [FT_W-1:0]   flush_timer;
    logic [ST_W-1:0]   stuck_timer;

    logic [CNT_W:0]    sum;
    logic              carry;
    logic [CNT_W-1:0]  acc_sat;
    logic              batch_hit;
    logic              resp_term;

    assign sum     = {1'b0, acc} + (CNT_W + 1)'(in_step);
    assign carry   = sum[CNT_W] && !halted;
    // Steps are frozen once halted; overflow saturates rather than wraps.
    assign acc_sat = halted ? acc : (carry ? '1 : sum[CNT_W-1:0]);

    assign batch_hit = (acc_sat >= BATCH_C) ||
                       ((acc_sat != '0) && (flush_timer == FT_LAST));

    assign resp_term = (resp_code != 8'd0) && (resp_code != 8'd3);

    assign dut_stall = halted || (acc >= STALL_C);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ACCUM;
            acc         <= '0;
            flush_timer <= '0;
            stuck_timer <= '0;
            req_valid   <= 1'b0;
            req_nstep   <= '0;
            perf_clean  <= 1'b0;
            perf_dump   <= 1'b0;
            halted      <= 1'b0;
            result      <= 8'd0;
            stuck       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            perf_clean <= 1'b0;
            perf_dump  <= 1'b0;

            if (carry) overflow <= 1'b1;

            if (!halted) begin
                if (in_step == '0) begin
                    if (stuck_timer != ST_MAX)
                        stuck_timer <= stuck_timer + ST_W'(1);
                    if (STUCK_LIMIT > 0 && stuck_timer >= ST_PRE)
                        stuck <= 1'b1;
                end else begin
                    stuck_timer <= '0;
                end
            end

            unique case (state)
                ACCUM: begin
                    if (batch_hit) begin
                        req_nstep   <= acc_sat;
                        req_valid   <= 1'b1;
                        acc         <= '0;
                        flush_timer <= '0;
                        state       <= ISSUE;
                    end else begin
                        acc         <= acc_sat;
                        flush_timer <= (acc_sat != '0) ?
                                       flush_timer + FT_W'(1) : '0;
                    end
                end
                ISSUE: begin
                    acc <= acc_sat;
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_valid && resp_term) begin
                        result    <= (resp_code == 8'd1) ? 8'd1 : 8'd2;
                        halted    <= 1'b1;
                        perf_dump <= 1'b1;
                        state     <= HALT;
                    end else begin
                        acc <= acc_sat;
                        if (resp_valid) begin
                            perf_clean <= (resp_code == 8'd3);
                            state      <= ACCUM;
                        end
                    end
                end
                HALT: begin
                    req_valid <= 1'b0;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Directed bench for difftest_step_scheduler: batching, flush,
// back-pressure, stall, result decode, stuck and async reset.
module tb_difftest_step_scheduler;

    logic        clock;
    logic        reset;
    logic [7:0]  in_step;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_nstep;
    logic        resp_valid;
    logic [7:0]  resp_code;
    logic        dut_stall;
    logic        perf_clean;
    logic        perf_dump;
    logic        halted;
    logic [7:0]  result;
    logic        stuck;
    logic        overflow;

    int checks;
    int failures;

    difftest_step_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .in_step    (in_step),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_nstep  (req_nstep),
        .resp_valid (resp_valid),
        .resp_code  (resp_code),
        .dut_stall  (dut_stall),
        .perf_clean (perf_clean),
        .perf_dump  (perf_dump),
        .halted     (halted),
        .result     (result),
        .stuck      (stuck),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_step    = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_code  = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({req_valid, dut_stall, perf_clean, perf_dump, halted,
             stuck, overflow} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0",
                     {req_valid, dut_stall, perf_clean, perf_dump,
                      halted, stuck, overflow});
        end
        checks++;
        if (req_nstep !== 16'd0 || result !== 8'd0) begin
            failures++;
            $display("FAIL reset_data nstep=%0d result=%0d exp=0",
                     req_nstep, result);
        end
    endtask

    task automatic test_batch();
        do_reset();
        req_ready = 1'b1;
        in_step   = 8'd8;
        repeat (7) tick();
        checks++;
        if (req_valid !== 1'b0) begin
            failures++;
            $display("FAIL batch_early got=%b exp=0", req_valid);
        end
        tick();
        in_step = 8'd0;
        checks++;
        if (req_valid !== 1'b1 || req_nstep !== 16'd64) begin
            failures++;
            $display("FAIL batch_issue valid=%b nstep=%0d exp=1/64",
                     req_valid, req_nstep);
        end
        tick();
        checks++;
        if (req_valid !== 1'b0) begin
            failures++;
            $display("FAIL batch_handshake got=%b exp=0", req_valid);
        end
        repeat (40) tick();
        checks++;
        if (req_valid !== 1'b0) begin
            failures++;
            $display("FAIL batch_single got=%b exp=0", req_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        req_ready = 1'b1;
        repeat (40) tick();
        checks++;
        if (req_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_zero_len got=%b exp=0", req_valid);
        end
        in_step = 8'd5;
        tick();
        in_step = 8'd0;
        repeat (30) tick();
        checks++;
        if (req_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_early got=%b exp=0", req_valid);
        end
        tick();
        checks++;
        if (req_valid !== 1'b1 || req_nstep !== 16'd5) begin
            failures++;
            $display("FAIL flush_issue valid=%b nstep=%0d exp=1/5",
                     req_valid, req_nstep);
        end
    endtask

    task automatic test_back_to_back();
        logic held;
        do_reset();
        req_ready = 1'b0;
        in_step   = 8'd8;
        repeat (8) tick();
        in_step = 8'd10;
        held    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req_valid !== 1'b1 || req_nstep !== 16'd64) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold valid=%b nstep=%0d exp=1/64",
                     req_valid, req_nstep);
        end
        in_step   = 8'd0;
        req_ready = 1'b1;
        tick();
        checks++;
        if (req_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept got=%b exp=0", req_valid);
        end
        resp_valid = 1'b1;
        resp_code  = 8'd0;
        tick();
        resp_valid = 1'b0;
        tick();
        checks++;
        if (req_valid !== 1'b1 || req_nstep !== 16'd100) begin
            failures++;
            $display("FAIL bp_next valid=%b nstep=%0d exp=1/100",
                     req_valid, req_nstep);
        end
    endtask

    task automatic test_stall();
        do_reset();
        req_ready = 1'b0;
        in_step   = 8'd200;
        repeat (6) tick();
        checks++;
        if (dut_stall !== 1'b0) begin
            failures++;
            $display("FAIL stall_early got=%b exp=0", dut_stall);
        end
        tick();
        checks++;
        if (dut_stall !== 1'b1) begin
            failures++;
            $display("FAIL stall_set got=%b exp=1", dut_stall);
        end
        checks++;
        if (overflow !== 1'b0 || req_nstep !== 16'd200) begin
            failures++;
            $display("FAIL stall_ovf ovf=%b nstep=%0d exp=0/200",
                     overflow, req_nstep);
        end
        in_step = 8'd0;
    endtask

    task automatic test_codes();
        logic quiet;
        do_reset();
        req_ready = 1'b1;
        in_step   = 8'd64;
        tick();
        in_step = 8'd0;
        tick();
        resp_valid = 1'b1;
        resp_code  = 8'd3;
        tick();
        resp_valid = 1'b0;
        checks++;
        if (perf_clean !== 1'b1 || perf_dump !== 1'b0) begin
            failures++;
            $display("FAIL warmup_pulse clean=%b dump=%b exp=1/0",
                     perf_clean, perf_dump);
        end
        resp_valid = 1'b1;
        resp_code  = 8'd1;
        tick();
        resp_valid = 1'b0;
        checks++;
        if (perf_clean !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL resp_ignored clean=%b halted=%b exp=0/0",
                     perf_clean, halted);
        end
        in_step = 8'd64;
        tick();
        in_step = 8'd0;
        tick();
        resp_valid = 1'b1;
        resp_code  = 8'd1;
        tick();
        resp_valid = 1'b0;
        checks++;
        if (halted !== 1'b1 || result !== 8'd1 || perf_dump !== 1'b1) begin
            failures++;
            $display("FAIL done_halt h=%b r=%0d dump=%b exp=1/1/1",
                     halted, result, perf_dump);
        end
        tick();
        checks++;
        if (perf_dump !== 1'b0 || dut_stall !== 1'b1) begin
            failures++;
            $display("FAIL done_after dump=%b stall=%b exp=0/1",
                     perf_dump, dut_stall);
        end
        in_step = 8'd100;
        quiet   = 1'b1;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (req_valid !== 1'b0 || halted !== 1'b1) quiet = 1'b0;
        end
        in_step = 8'd0;
        checks++;
        if (quiet !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL halt_frozen valid=%b ovf=%b exp=0/0",
                     req_valid, overflow);
        end
    endtask

    task automatic test_reserved();
        do_reset();
        req_ready = 1'b1;
        in_step   = 8'd70;
        tick();
        in_step = 8'd0;
        tick();
        resp_valid = 1'b1;
        resp_code  = 8'd9;
        tick();
        resp_valid = 1'b0;
        checks++;
        if (halted !== 1'b1 || result !== 8'd2 || perf_dump !== 1'b1) begin
            failures++;
            $display("FAIL reserved_fail h=%b r=%0d dump=%b exp=1/2/1",
                     halted, result, perf_dump);
        end
    endtask

    task automatic test_stuck_reset();
        do_reset();
        in_step = 8'd0;
        repeat (4999) tick();
        checks++;
        if (stuck !== 1'b0) begin
            failures++;
            $display("FAIL stuck_early got=%b exp=0", stuck);
        end
        repeat (3) tick();
        checks++;
        if (stuck !== 1'b1) begin
            failures++;
            $display("FAIL stuck_set got=%b exp=1", stuck);
        end
        req_ready = 1'b0;
        in_step   = 8'd64;
        tick();
        in_step = 8'd0;
        tick();
        checks++;
        if (req_valid !== 1'b1 || stuck !== 1'b1) begin
            failures++;
            $display("FAIL stuck_issue valid=%b stuck=%b exp=1/1",
                     req_valid, stuck);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({req_valid, stuck, halted, dut_stall} !== 4'b0 ||
            req_nstep !== 16'd0) begin
            failures++;
            $display("FAIL async_reset flags=%b nstep=%0d exp=0",
                     {req_valid, stuck, halted, dut_stall}, req_nstep);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (40) tick();
        checks++;
        if (req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_lost got=%b exp=0", req_valid);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        in_step    = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_code  = '0;
        test_reset();
        test_batch();
        test_flush();
        test_back_to_back();
        test_stall();
        test_codes();
        test_reserved();
        test_stuck_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
